audio_sample_fifo: RTL and testbench

//  Elastic buffer between the monitor-link packet decoder and the I2S serializer.
//  - Stores 32-bit stereo audio samples taken from incoming packets.
//  - Hands one sample per I2S frame to the serializer; in 22 kHz mode each sample is repeated once.
//  - Drives the sample-request handshake that the packet sender turns into request packets to the host.
//  - Single clock domain: mon_clk. The I2S side supplies a frame strobe already in mon_clk.

---
 rtl/nextasic_pkg.sv | 10 +
 rtl/sample_ring.sv | 56 +++++
 rtl/audio_sample_fifo.sv | 130 +++++++++++++
 tb/tb_audio_sample_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nextasic_pkg.sv
// nextasic_pkg: shared widths and request-FSM state encodings for the audio path.
//   AUDIO_SAMPLE_W : one stereo sample, [31:16] left, [15:0] right
//   req_state_e    : sample-request FSM states (REQ_IDLE, REQ_WAIT)
package nextasic_pkg;
  localparam int AUDIO_SAMPLE_W = 32;
  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_WAIT = 1'b1
  } req_state_e;
endpackage

// File: rtl/sample_ring.sv
// sample_ring: circular sample store with explicit fill level.
//   clk, rst_n        : clock, async active-low reset
//   i_flush           : drop all contents; a write in the same cycle is discarded
//   i_wr, i_wr_data   : write request and sample
//   i_rd              : pop request (ignored when empty)
//   o_head            : sample at the read pointer
//   o_level           : fill count 0..2**DEPTH_LOG2
//   o_full, o_empty   : level flags
module sample_ring
  import nextasic_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_flush,
  input  logic                      i_wr,
  input  logic [AUDIO_SAMPLE_W-1:0] i_wr_data,
  input  logic                      i_rd,
  output logic [AUDIO_SAMPLE_W-1:0] o_head,
  output logic [DEPTH_LOG2:0]       o_level,
  output logic                      o_full,
  output logic                      o_empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  logic [AUDIO_SAMPLE_W-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]     r_wr_ptr;
  logic [DEPTH_LOG2-1:0]     r_rd_ptr;
  logic [DEPTH_LOG2:0]       r_level;
  logic                      w_rd;
  logic                      w_wr;
  assign o_level = r_level;
  assign o_full  = r_level == FULL_LVL;
  assign o_empty = r_level == '0;
  assign o_head  = r_mem[r_rd_ptr];
  // A pop frees a slot in the same cycle, so a full ring still accepts a write alongside it.
  assign w_rd = i_rd & ~o_empty & ~i_flush;
  assign w_wr = i_wr & (~o_full | w_rd) & ~i_flush;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      r_level <= r_level + (DEPTH_LOG2 + 1)'(w_wr) - (DEPTH_LOG2 + 1)'(w_rd);
    end
endmodule

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: elastic sample buffer between packet decoder and I2S, with sample-request FSM.
//   mon_clk, rst_n     : sole clock, async active-low reset
//   i_audio_starts     : playback enable; falling edge flushes the block
//   i_audio_22khz      : repeat each sample for two frames
//   i_in_valid/i_in_data : incoming sample strobe and data
//   i_frame_req        : I2S wants the next frame sample
//   o_out_data/o_out_valid : sample presented to I2S (valid = 0 means silence)
//   o_req_mode         : i_audio_starts delayed one stage
//   o_req_tick         : pulse to send one sample-request packet
//   o_level            : current fill count
//   o_underrun/o_overrun : pulses for read-on-empty and write-on-full
module audio_sample_fifo
  import nextasic_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int LOW_WATER  = 4,
  parameter int RETRY      = 16000,
  parameter int RW         = 14
) (
  input  logic                      mon_clk,
  input  logic                      rst_n,
  input  logic                      i_audio_starts,
  input  logic                      i_audio_22khz,
  input  logic                      i_in_valid,
  input  logic [AUDIO_SAMPLE_W-1:0] i_in_data,
  input  logic                      i_frame_req,
  output logic [AUDIO_SAMPLE_W-1:0] o_out_data,
  output logic                      o_out_valid,
  output logic                      o_req_mode,
  output logic                      o_req_tick,
  output logic [DEPTH_LOG2:0]       o_level,
  output logic                      o_underrun,
  output logic                      o_overrun
);
  logic [AUDIO_SAMPLE_W-1:0] w_head;
  logic [DEPTH_LOG2:0]       w_level;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_stop;
  logic                      w_need_pop;
  logic                      w_pop;
  logic                      w_low;
  logic                      w_tick;
  req_state_e                r_state;
  req_state_e                w_state_nx;
  logic [RW-1:0]             r_cnt;
  logic [RW-1:0]             w_cnt_nx;
  logic                      r_phase;
  // Falling edge of audio_starts: the registered copy is still high while the input is low.
  assign w_stop     = o_req_mode & ~i_audio_starts;
  // In 22 kHz mode the second frame of each pair repeats the held sample instead of popping.
  assign w_need_pop = i_frame_req & ~(i_audio_22khz & r_phase);
  assign w_pop      = w_need_pop & ~w_empty;
  assign w_low      = w_level <= (DEPTH_LOG2 + 1)'(LOW_WATER);
  assign o_level    = w_level;
  sample_ring #(.DEPTH_LOG2(DEPTH_LOG2)) u_ring (
    .clk       (mon_clk),
    .rst_n     (rst_n),
    .i_flush   (w_stop),
    .i_wr      (i_in_valid),
    .i_wr_data (i_in_data),
    .i_rd      (w_need_pop),
    .o_head    (w_head),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_tick     = 1'b0;
    if (r_state == REQ_IDLE) begin
      if (o_req_mode & w_low) begin
        w_tick     = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = REQ_WAIT;
      end
    end else if (!w_low) begin
      w_state_nx = REQ_IDLE;
    end else if (r_cnt == RW'(RETRY - 1)) begin
      w_tick   = 1'b1;
      w_cnt_nx = '0;
    end else begin
      w_cnt_nx = r_cnt + RW'(1);
    end
    if (w_stop) begin
      w_state_nx = REQ_IDLE;
      w_cnt_nx   = '0;
      w_tick     = 1'b0;
    end
  end
  always_ff @(posedge mon_clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= REQ_IDLE;
      r_cnt      <= '0;
      o_req_mode <= 1'b0;
      o_req_tick <= 1'b0;
      o_underrun <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      o_req_mode <= i_audio_starts;
      o_req_tick <= w_tick;
      o_underrun <= w_need_pop & w_empty & ~w_stop;
      o_overrun  <= i_in_valid & w_full & ~w_pop & ~w_stop;
    end
  always_ff @(posedge mon_clk or negedge rst_n)
    if (!rst_n) begin
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
      r_phase     <= 1'b0;
    end else if (w_stop) begin
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
      r_phase     <= 1'b0;
    end else if (i_frame_req) begin
      if (i_audio_22khz & r_phase) begin
        r_phase <= 1'b0;
      end else if (w_empty) begin
        o_out_data  <= '0;
        o_out_valid <= 1'b0;
        r_phase     <= 1'b0;
      end else begin
        o_out_data  <= w_head;
        o_out_valid <= 1'b1;
        r_phase     <= i_audio_22khz;
      end
    end
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: directed stimulus with a scoreboard of expected I2S samples and pulse counters.
module tb_audio_sample_fifo;
  logic        mon_clk;
  logic        rst_n;
  logic        i_audio_starts;
  logic        i_audio_22khz;
  logic        i_in_valid;
  logic [31:0] i_in_data;
  logic        i_frame_req;
  logic [31:0] o_out_data;
  logic        o_out_valid;
  logic        o_req_mode;
  logic        o_req_tick;
  logic [3:0]  o_level;
  logic        o_underrun;
  logic        o_overrun;
  int          n_chk;
  int          n_pass;
  int          n_tick;
  int          n_under;
  int          n_over;
  logic        prev_tick;
  logic        fr_d;
  logic [32:0] exp_q[$];
  audio_sample_fifo dut (
    .mon_clk        (mon_clk),
    .rst_n          (rst_n),
    .i_audio_starts (i_audio_starts),
    .i_audio_22khz  (i_audio_22khz),
    .i_in_valid     (i_in_valid),
    .i_in_data      (i_in_data),
    .i_frame_req    (i_frame_req),
    .o_out_data     (o_out_data),
    .o_out_valid    (o_out_valid),
    .o_req_mode     (o_req_mode),
    .o_req_tick     (o_req_tick),
    .o_level        (o_level),
    .o_underrun     (o_underrun),
    .o_overrun      (o_overrun)
  );
  initial mon_clk = 1'b0;
  always #5 mon_clk = ~mon_clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // Remember which cycles carried a frame request; the output is due one edge later.
  always @(posedge mon_clk or negedge rst_n)
    if (!rst_n) fr_d <= 1'b0;
    else fr_d <= i_frame_req;
  always @(negedge mon_clk)
    if (rst_n) begin
      if (fr_d) begin
        if (exp_q.size() == 0) chk("sb_unexpected_frame", 1, 0);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("out_data", o_out_data, e[31:0]);
          chk("out_valid", o_out_valid, e[32]);
        end
      end
      if (o_req_tick) begin
        n_tick++;
        chk("tick_back_to_back", prev_tick, 0);
      end
      prev_tick = o_req_tick;
      if (o_underrun) n_under++;
      if (o_overrun) n_over++;
    end
  task automatic tick();
    @(posedge mon_clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] d);
    i_in_valid = 1'b1;
    i_in_data  = d;
    tick();
    i_in_valid = 1'b0;
  endtask
  task automatic fr(input logic [31:0] d, input logic v);
    exp_q.push_back({v, d});
    i_frame_req = 1'b1;
    tick();
    i_frame_req = 1'b0;
  endtask
  initial begin
    int n;
    int t0;
    int u0;
    int o0;
    n_chk = 0; n_pass = 0; n_tick = 0; n_under = 0; n_over = 0; prev_tick = 1'b0;
    rst_n = 1'b0;
    i_audio_starts = 1'b0; i_audio_22khz = 1'b0;
    i_in_valid = 1'b0; i_in_data = '0; i_frame_req = 1'b0;
    repeat (3) tick();
    chk("rst_level", o_level, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_req_tick", o_req_tick, 0);
    chk("rst_underrun", o_underrun, 0);
    rst_n = 1'b1;
    tick();
    // 1: three samples through in order
    u0 = n_under;
    wr(32'h1111_2222); wr(32'h3333_4444); wr(32'h5555_6666);
    chk("t1_level3", o_level, 3);
    fr(32'h1111_2222, 1); fr(32'h3333_4444, 1); fr(32'h5555_6666, 1);
    tick();
    chk("t1_level0", o_level, 0);
    chk("t1_no_underrun", n_under, u0);
    // 2: 22 kHz repeat A A B B
    i_audio_22khz = 1'b1;
    wr(32'hAAAA_0001); wr(32'hBBBB_0002);
    fr(32'hAAAA_0001, 1); chk("t2_lvl_s1", o_level, 1);
    fr(32'hAAAA_0001, 1); chk("t2_lvl_s2", o_level, 1);
    fr(32'hBBBB_0002, 1); chk("t2_lvl_s3", o_level, 0);
    fr(32'hBBBB_0002, 1); chk("t2_lvl_s4", o_level, 0);
    i_audio_22khz = 1'b0;
    tick();
    chk("t2_no_underrun", n_under, u0);
    // 3: overfill, ninth sample dropped
    o0 = n_over;
    for (int i = 0; i < 9; i++) wr(32'hC0DE_0000 + 32'(i));
    tick();
    chk("t3_level_full", o_level, 8);
    chk("t3_overrun_once", n_over, o0 + 1);
    for (int i = 0; i < 8; i++) fr(32'hC0DE_0000 + 32'(i), 1);
    tick();
    chk("t3_level_drained", o_level, 0);
    // 5: frame_req and write together on empty: no bypass
    exp_q.push_back({1'b0, 32'h0});
    i_frame_req = 1'b1; i_in_valid = 1'b1; i_in_data = 32'hCAFE_F00D;
    tick();
    i_frame_req = 1'b0; i_in_valid = 1'b0;
    tick();
    chk("t5_underrun", n_under, u0 + 1);
    chk("t5_level1", o_level, 1);
    fr(32'hCAFE_F00D, 1);
    tick();
    chk("t5_level0", o_level, 0);
    // 4: request FSM
    t0 = n_tick;
    chk("t4_no_tick_while_off", n_tick, 0);
    i_audio_starts = 1'b1;
    tick();
    chk("t4_req_mode", o_req_mode, 1);
    chk("t4_tick_not_yet", o_req_tick, 0);
    tick();
    chk("t4_first_tick", o_req_tick, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_req_tick && n < 20000);
    chk("t4_retry_gap", n, 16000);
    for (int i = 0; i < 5; i++) wr(32'hD000_0000 + 32'(i));
    chk("t4_level5", o_level, 5);
    t0 = n_tick;
    repeat (50) tick();
    chk("t4_no_more_ticks", n_tick, t0);
    // 6: falling audio_starts flushes
    chk("t6_valid_before", o_out_valid, 1);
    i_audio_starts = 1'b0;
    tick();
    chk("t6_level_flushed", o_level, 0);
    chk("t6_valid_cleared", o_out_valid, 0);
    chk("t6_out_cleared", o_out_data, 0);
    repeat (20) tick();
    chk("t6_no_tick", n_tick, t0);
    chk("t6_req_mode_off", o_req_mode, 0);
    // async reset mid-stream
    i_audio_starts = 1'b1;
    wr(32'hE000_0001); wr(32'hE000_0002);
    fr(32'hE000_0001, 1);
    repeat (2) tick();
    @(posedge mon_clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_level", o_level, 0);
    chk("ar_out_data", o_out_data, 0);
    chk("ar_out_valid", o_out_valid, 0);
    chk("ar_req_mode", o_req_mode, 0);
    chk("ar_req_tick", o_req_tick, 0);
    i_audio_starts = 1'b0;
    tick();
    rst_n = 1'b1;
    t0 = n_tick; u0 = n_under; o0 = n_over;
    repeat (10) tick();
    chk("ar_no_tick_after", n_tick, t0);
    chk("ar_no_under_after", n_under, u0);
    chk("ar_no_over_after", n_over, o0);
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
